// File: rtl/usb_pkg.sv
// Shared USB transmit-side types: PID codes, SYNC pattern and sender FSM states.
// Used by pid_sender; PID_SENDER_SYNC_EN selects whether the SYNC prefix is sent.
package usb_pkg;

  typedef enum logic [3:0] {
    OUT   = 4'b0001,
    IN    = 4'b1001,
    SOF   = 4'b0101,
    SETUP = 4'b1101,
    DATA0 = 4'b0011,
    DATA1 = 4'b1011,
    ACK   = 4'b0010,
    NAK   = 4'b1010,
    STALL = 4'b1110
  } pid_t;

  localparam logic [7:0] SYNC_BYTE = 8'b1000_0000;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SYNC = 2'd1,
    TX_PID  = 2'd2,
    TX_DONE = 2'd3
  } tx_state_t;

  // Wire image of a PID byte: check nibble above the PID nibble, sent LSB first.
  function automatic logic [7:0] pid_byte(input pid_t p);
    return {~p, p};
  endfunction

endpackage

// File: rtl/pid_sender_fsm.sv
// State register and next-state logic for pid_sender.
// With PID_SENDER_SYNC_EN undefined the SYNC state is never entered.
module pid_sender_fsm
  import usb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start_PID,
  input  logic      cnt_last,
  output tx_state_t cs,
  output tx_state_t ns
);

  tx_state_t w_first;

`ifdef PID_SENDER_SYNC_EN
  assign w_first = TX_SYNC;
`else
  assign w_first = TX_PID;
`endif

  always_comb begin
    ns = cs;
    case (cs)
      TX_IDLE: if (start_PID) ns = w_first;
      TX_SYNC: if (cnt_last) ns = TX_PID;
      TX_PID:  if (cnt_last) ns = TX_DONE;
      TX_DONE: ns = start_PID ? w_first : TX_IDLE;
      default: ns = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cs <= TX_IDLE;
    else     cs <= ns;
  end

endmodule

// File: rtl/pid_sender.sv
// Serializes an optional SYNC byte then a PID byte, LSB first, one bit per clock.
// Define PID_SENDER_SYNC_EN to send the 8-bit SYNC prefix before the PID.
module pid_sender
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_PID,
  input  pid_t pid_in,
  output logic s_out,
  output logic s_valid,
  output logic busy,
  output logic end_PID
);

  tx_state_t  w_cs;
  tx_state_t  w_ns;
  logic       w_accept;
  logic       w_cnt_last;
  logic [7:0] r_shift;
  logic [2:0] r_cnt;
  logic       r_s_out;
  logic       r_s_valid;
  logic       r_busy;
  logic       r_end;

  pid_sender_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start_PID (start_PID),
    .cnt_last  (w_cnt_last),
    .cs        (w_cs),
    .ns        (w_ns)
  );

  assign w_cnt_last = (r_cnt == 3'd7);
  // A start is taken only when the FSM leaves IDLE or DONE for a field state.
  assign w_accept = ((w_cs == TX_IDLE) || (w_cs == TX_DONE)) &&
                    ((w_ns == TX_SYNC) || (w_ns == TX_PID));

  // Outputs trail the state by one cycle, so bit k leaves while the counter holds k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= 8'd0;
      r_cnt     <= 3'd0;
      r_s_out   <= 1'b0;
      r_s_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_end     <= 1'b0;
    end else begin
      r_s_out   <= 1'b0;
      r_s_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_end     <= 1'b0;
      case (w_cs)
        TX_SYNC: begin
          r_s_out   <= SYNC_BYTE[r_cnt];
          r_s_valid <= 1'b1;
          r_busy    <= 1'b1;
          r_cnt     <= r_cnt + 3'd1;
        end
        TX_PID: begin
          r_s_out   <= r_shift[0];
          r_shift   <= {1'b0, r_shift[7:1]};
          r_s_valid <= 1'b1;
          r_busy    <= 1'b1;
          r_cnt     <= r_cnt + 3'd1;
        end
        TX_DONE: begin
          r_end <= 1'b1;
          r_cnt <= 3'd0;
        end
        default: r_cnt <= 3'd0;
      endcase
      if (w_accept) r_shift <= pid_byte(pid_in);
    end
  end

  assign s_out   = r_s_out;
  assign s_valid = r_s_valid;
  assign busy    = r_busy;
  assign end_PID = r_end;

endmodule

// File: tb/tb_pid_sender.sv
// Self-checking bench for pid_sender; expected serial frames come from a bit-list model.
// Follows PID_SENDER_SYNC_EN so it matches whichever build is compiled.
module tb_pid_sender;
  import usb_pkg::*;

`ifdef PID_SENDER_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_PID;
  logic [3:0] pid_raw;
  pid_t       pid_in;
  logic       s_out;
  logic       s_valid;
  logic       busy;
  logic       end_PID;

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  assign pid_in = pid_t'(pid_raw);

  pid_sender dut (
    .clk       (clk),
    .rst       (rst),
    .start_PID (start_PID),
    .pid_in    (pid_in),
    .s_out     (s_out),
    .s_valid   (s_valid),
    .busy      (busy),
    .end_PID   (end_PID)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: the frame is simply a list of bits in wire order
  function automatic void build_frame(input logic [3:0] p);
    exp_q.delete();
    if (SYNC_EN) begin
      for (int i = 0; i < 7; i++) exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(p[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(~p[i]);
  endfunction

  // drive a start pulse from IDLE; returns in the acceptance cycle
  task automatic launch(input logic [3:0] p);
    logic [3:0] got;
    start_PID = 1'b1;
    pid_raw   = p;
    @(negedge clk);
    start_PID = 1'b0;
    got = {s_valid, busy, s_out, end_PID};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL accept_cycle pid=%h got v/b/d/e=%b exp=%b", p, got, 4'b0000);
    end
  endtask

  // mode 0 plain, 1 change pid_in mid-frame to p2, 2 stray starts while busy,
  // 3 chain a new start of p2 into the DONE cycle
  task automatic expect_bits(input logic [3:0] p, input int mode, input logic [3:0] p2);
    logic [3:0] got;
    logic [3:0] exp;
    int n;
    build_frame(p);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      if (mode == 1 && k == 3) pid_raw = p2;
      if (mode == 2) begin
        start_PID = (k == 2 || k == 5);
        pid_raw   = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      exp = {1'b1, 1'b1, exp_q[k], 1'b0};
      got = {s_valid, busy, s_out, end_PID};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL frame_bit%0d pid=%h got v/b/d/e=%b exp=%b", k, p, got, exp);
      end
    end
    start_PID = 1'b0;
    if (mode == 3) begin
      start_PID = 1'b1;
      pid_raw   = p2;
    end
    @(negedge clk);
    start_PID = 1'b0;
    got = {s_valid, busy, s_out, end_PID};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL end_pulse pid=%h got v/b/d/e=%b exp=%b", p, got, 4'b0001);
    end
    if (mode != 3) begin
      @(negedge clk);
      got = {s_valid, busy, s_out, end_PID};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL after_end pid=%h got v/b/d/e=%b exp=%b", p, got, 4'b0000);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst       = 1'b1;
    start_PID = 1'b0;
    pid_raw   = 4'd0;
    repeat (3) @(negedge clk);
    got = {s_valid, busy, s_out, end_PID};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values got v/b/d/e=%b exp=%b", got, 4'b0000);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_pids();
    launch(DATA0);
    expect_bits(DATA0, 0, 4'd0);
    launch(ACK);
    expect_bits(ACK, 0, 4'd0);
  endtask

  task automatic test_random();
    logic [3:0] p;
    repeat (12) begin
      p = 4'($urandom_range(0, 15));
      launch(p);
      expect_bits(p, 0, 4'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_pid_hold();
    launch(IN);
    expect_bits(IN, 1, STALL);
  endtask

  task automatic test_ignore_busy();
    launch(SETUP);
    expect_bits(SETUP, 2, 4'd0);
  endtask

  task automatic test_back_to_back();
    launch(ACK);
    expect_bits(ACK, 3, NAK);
    expect_bits(NAK, 3, SOF);
    expect_bits(SOF, 0, 4'd0);
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    int idx;
    launch(DATA1);
    build_frame(DATA1);
    idx = exp_q.size() - 8 + 5;
    for (int k = 0; k <= idx; k++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    got = {s_valid, busy, s_out, end_PID};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got v/b/d/e=%b exp=%b", got, 4'b0000);
    end
    repeat (2) begin
      @(negedge clk);
      got = {s_valid, busy, s_out, end_PID};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold got v/b/d/e=%b exp=%b", got, 4'b0000);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    got = {s_valid, busy, s_out, end_PID};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle got v/b/d/e=%b exp=%b", got, 4'b0000);
    end
    launch(OUT);
    expect_bits(OUT, 0, 4'd0);
  endtask

  task automatic test_reset_start_same();
    logic [3:0] got;
    rst       = 1'b1;
    start_PID = 1'b1;
    pid_raw   = STALL;
    @(negedge clk);
    rst       = 1'b0;
    start_PID = 1'b0;
    repeat (3) begin
      @(negedge clk);
      got = {s_valid, busy, s_out, end_PID};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL reset_beats_start got v/b/d/e=%b exp=%b", got, 4'b0000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_pids();
    test_random();
    test_pid_hold();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_reset_start_same();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
